// File: rtl/multiplier_core.sv
// multiplier_core: unsigned WIDTH x WIDTH array multiplier with a registered 2*WIDTH product.
// Latency: 1 cycle in_valid -> out_valid; 2 cycles when MULTIPLIER_CORE_IN_REG_EN is defined.
// Backpressure: none; every out_valid pulse must be taken by the consumer in that cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (P = 0, out_valid = 0)
//   in_valid   A/B are valid this cycle
//   A, B       unsigned operands, WIDTH bits each (WIDTH legal 2..16)
//   out_valid  P holds a newly computed product this cycle
//   P          registered unsigned product, 2*WIDTH bits
//
// Build option: define MULTIPLIER_CORE_IN_REG_EN to register A, B and in_valid
// ahead of the adder array (operand registers hold while in_valid is low).

module multiplier_core #(
  parameter int WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   P
);

  // Operands and strobe as seen by the adder array.
  logic [WIDTH-1:0] arr_a;
  logic [WIDTH-1:0] arr_b;
  logic             arr_vld;

`ifdef MULTIPLIER_CORE_IN_REG_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             in_valid_q;

  // Operand registers only load on a valid cycle so idle-cycle garbage
  // (including X) never enters the array.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (in_valid) begin
      a_d = A;
      b_d = B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      in_valid_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      in_valid_q <= in_valid;
    end
  end

  assign arr_a   = a_q;
  assign arr_b   = b_q;
  assign arr_vld = in_valid_q;
`else
  assign arr_a   = A;
  assign arr_b   = B;
  assign arr_vld = in_valid;
`endif

  // ---------------------------------------------------------------------------
  // AND-array / ripple-carry adder rows.
  //
  // Row j carries a WIDTH+1 bit running sum r. Row 0 is just the first
  // partial product. Each later row adds its partial product to the previous
  // row's sum shifted right by one; the bit shifted out is final and becomes
  // product bit j-1. The last row supplies the top WIDTH+1 product bits.
  // Every adder bit lives in its own generate scope so the carry chain is a
  // set of distinct nets rather than bits of one self-referencing vector.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod;

  for (genvar j = 0; j < WIDTH; j++) begin : g_row
    logic [WIDTH-1:0] pp;
    logic [WIDTH:0]   r;

    assign pp = arr_a & {WIDTH{arr_b[j]}};

    if (j == 0) begin : g_first
      assign r = {1'b0, pp};
    end else begin : g_add
      for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic x;
        logic y;
        logic ci;
        logic s;
        logic co;

        assign x = g_row[j-1].r[i+1];
        assign y = pp[i];

        // Bit 0 of each row has no carry in, so it reduces to a half adder.
        if (i == 0) begin : g_ci0
          assign ci = 1'b0;
        end else begin : g_cin
          assign ci = g_fa[i-1].co;
        end

        assign s  = x ^ y ^ ci;
        assign co = (x & y) | (ci & (x ^ y));

        assign r[i] = s;
      end

      assign r[WIDTH] = g_fa[WIDTH-1].co;
    end

    // Low product bits drop out of the array one per row.
    if (j < WIDTH-1) begin : g_lsb
      assign prod[j] = r[0];
    end
  end

  assign prod[2*WIDTH-1:WIDTH-1] = g_row[WIDTH-1].r;

  // ---------------------------------------------------------------------------
  // Product register: loads on a valid cycle, otherwise holds; out_valid is a
  // one-cycle strobe per accepted operand pair.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               out_valid_q, out_valid_d;

  always_comb begin
    p_d         = p_q;
    out_valid_d = arr_vld;
    if (arr_vld) begin
      p_d = prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign P         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_core.sv
// Directed bench for multiplier_core: a WIDTH=2 instance (exhaustive, streaming,
// bubble, reset cases) and a WIDTH=8 instance (corner products).
module tb_multiplier_core;

`ifdef MULTIPLIER_CORE_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic [1:0]  A, B;
  logic        out_valid;
  logic [3:0]  P;

  logic        in_valid8;
  logic [7:0]  a8, b8;
  logic        out_valid8;
  logic [15:0] p8;

  int n_checks;
  int n_fail;

  multiplier_core #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(out_valid), .P(P)
  );

  multiplier_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .A(a8), .B(b8),
    .out_valid(out_valid8), .P(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid pulse on the 2-bit instance, then idle with random operands.
  task automatic apply2(input logic [1:0] a, input logic [1:0] b, input logic [3:0] exp, input string tag);
    A = a; B = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = 2'($urandom); B = 2'($urandom);
    repeat (LAT-1) tick();
    check({tag, "_p"}, 32'(P), 32'(exp));
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    tick();
    check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_hold"}, 32'(P), 32'(exp));
  endtask

  task automatic apply8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string tag);
    a8 = a; b8 = b; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    repeat (LAT-1) tick();
    check({tag, "_p"}, 32'(p8), 32'(exp));
    check({tag, "_vld"}, 32'(out_valid8), 32'd1);
    tick();
    check({tag, "_vld_drop"}, 32'(out_valid8), 32'd0);
  endtask

  logic [1:0] s_a   [3];
  logic [1:0] s_b   [3];
  logic [3:0] s_exp [3];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    in_valid = 1'b0; A = '0; B = '0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;

    tick(); tick();
    check("reset_p", 32'(P), 32'd0);
    check("reset_vld", 32'(out_valid), 32'd0);
    check("reset_p8", 32'(p8), 32'd0);
    rst = 1'b0;
    tick();

    // Hand-computed anchors.
    apply2(2'd2, 2'd3, 4'b0110, "m2x3");
    apply2(2'd3, 2'd3, 4'b1001, "m3x3");
    apply2(2'd0, 2'd3, 4'b0000, "m0x3");
    apply2(2'd1, 2'd2, 4'b0010, "m1x2");

    // Exhaustive 2-bit operand space.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        apply2(2'(a), 2'(b), 4'(a * b), $sformatf("ex_%0d_%0d", a, b));
      end
    end

    // Back-to-back stream at full throughput.
    s_a[0] = 2'd1; s_b[0] = 2'd1; s_exp[0] = 4'd1;
    s_a[1] = 2'd2; s_b[1] = 2'd2; s_exp[1] = 4'd4;
    s_a[2] = 2'd3; s_b[2] = 2'd3; s_exp[2] = 4'd9;
    for (int k = 0; k < 3 + LAT - 1; k++) begin
      if (k < 3) begin
        A = s_a[k]; B = s_b[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k >= LAT - 1) begin
        check($sformatf("stream_p%0d", k - LAT + 1), 32'(P), 32'(s_exp[k - LAT + 1]));
        check($sformatf("stream_vld%0d", k - LAT + 1), 32'(out_valid), 32'd1);
      end
    end
    in_valid = 1'b0;
    tick();
    check("stream_vld_end", 32'(out_valid), 32'd0);

    // Bubble: idle operands 3x3 must not disturb a held product of 6.
    apply2(2'd2, 2'd3, 4'd6, "bub_load");
    A = 2'd3; B = 2'd3; in_valid = 1'b0;
    repeat (LAT + 1) tick();
    check("bubble_p", 32'(P), 32'd6);
    check("bubble_vld", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle while P = 9.
    apply2(2'd3, 2'd3, 4'd9, "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_p", 32'(P), 32'd0);
    check("async_rst_vld", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Reset while an operand pair is in flight.
    A = 2'd3; B = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      check($sformatf("inflight_vld%0d", k), 32'(out_valid), 32'd0);
    end
    check("inflight_p", 32'(P), 32'd0);

    // First capture after reset behaves normally.
    apply2(2'd2, 2'd2, 4'd4, "first_after_rst");

    // WIDTH=8 corners.
    apply8(8'd255, 8'd255, 16'hFE01, "w8_255x255");
    apply8(8'd0,   8'd255, 16'd0,    "w8_0x255");
    apply8(8'd128, 8'd2,   16'd256,  "w8_128x2");
    apply8(8'd15,  8'd17,  16'd255,  "w8_15x17");
    apply8(8'd200, 8'd3,   16'd600,  "w8_200x3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_core.md
# multiplier_core

Unsigned integer multiplier for the datapath arithmetic library. It forms `P = A × B` with a structural AND-array / full-adder-row multiplier and registers the full-width product behind a valid strobe. With the default width it is the 2×2-bit multiplier whose product spans 0..9. It sits between an operand source that asserts `in_valid` and a consumer that samples `P` on `out_valid`.

## Interface
- `WIDTH`, default 2: operand width in bits, legal 2..16; product width is 2·WIDTH.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: `A`/`B` are valid this cycle.
- `A` input WIDTH: unsigned multiplicand.
- `B` input WIDTH: unsigned multiplier.
- `out_valid` output 1: `P` holds a new product this cycle.
- `P` output 2·WIDTH: unsigned product, registered.

## Operation
- Arithmetic:
  - Partial products are `pp[j][i] = A[i] & B[j]`.
  - The rows are summed by a ripple-carry array of full/half adders, one adder row per `B` bit after the first.
  - Do not use the `*` operator. A generate-loop structure is required.
- Width rules:
  - The result is exact; no truncation or overflow is possible.
  - The maximum result is (2^WIDTH−1)², e.g. 3×3 = 9 = 4'b1001 for WIDTH=2.
- Product register:
  - When `in_valid`=1 on a rising edge, the product register loads the product of the sampled operands and `out_valid` is set to 1.
  - When `in_valid`=0 on a rising edge, `P` holds its previous value and `out_valid` is set to 0.
- There is no backpressure: the consumer must accept every `out_valid` pulse.
- Back-to-back `in_valid` every cycle is supported at full throughput, one product per cycle.
- Operands outside the valid cycle are don't-care. X on `A`/`B` with `in_valid`=0 must not reach `P`.

## Timing
- Reset value of every output: `P` = 0 and `out_valid` = 0, applied immediately on `rst` assertion and independent of `clk`.
- Latency:
  - 1 cycle from `in_valid` to `out_valid` in the base build.
  - 2 cycles with `MULTIPLIER_CORE_IN_REG_EN`.
- Reset mid-operation: any in-flight product is discarded. No `out_valid` is produced for operands sampled before or during reset.
- First capture after reset: the first rising edge with `rst` deasserted and `in_valid`=1 captures operands normally.
- Combinational path: operand (or input register) → adder array → `P` register. The array depth is WIDTH rows.

## Configuration
- `MULTIPLIER_CORE_IN_REG_EN` defined:
  - `A`, `B` and `in_valid` are registered before the array, with reset values 0.
  - Latency is 2 cycles; throughput is still 1 per cycle.
  - When `in_valid`=0, the operand registers hold.
- Not defined:
  - The array is fed directly from the ports.
  - Latency is 1 cycle.
- Reset behaviour and `P` hold semantics are identical in both builds.

## Test plan
- Assert `rst` asynchronously mid-cycle with `P`=9 → `P`=0 and `out_valid`=0 immediately, before the next edge.
- Exhaustive WIDTH=2: A,B ∈ 0..3, one `in_valid` pulse each → `P` = A·B after latency, e.g. 2×3 → 4'b0110, 3×3 → 4'b1001, 0×3 → 0; `out_valid` exactly one cycle per pulse.
- Back-to-back stream (1,1),(2,2),(3,3) on consecutive cycles → `P` = 1, 4, 9 on consecutive cycles with `out_valid` held high.
- Bubble: product 6, then `in_valid`=0 with A=3,B=3 → `P` stays 6 and `out_valid`=0.
- Reset during in-flight operand (IN_REG build, A=3,B=2 sampled, then `rst`) → no `out_valid`; `P`=0.
- WIDTH=8 corners: 255×255 → 65025 (16'hFE01); 0×255 → 0; 128×2 → 256.
